// File: rtl/data_connection_block_cfg_if.sv
// Channel-side and pin-side signals of one connection block, plus its serial config port.
interface data_connection_block_cfg_if #(
  parameter int unsigned W       = 16,
  parameter int unsigned WW      = 4,
  parameter int unsigned DATAIN  = 4,
  parameter int unsigned DATAOUT = 3
);
  logic [W-1:0]            track_in;
  logic [W-1:0]            track_out;
  logic [W-1:0]            track_oe;
  logic [WW*DATAIN-1:0]    data_input;
  logic [WW*DATAOUT-1:0]   data_output;
  logic                    cfg_shift;
  logic                    cfg_in;
  logic                    cfg_out;
  logic                    cfg_commit;
  logic                    cfg_loaded;
  logic                    cfg_error;
  logic                    conflict;

  // Environment side: drives tracks, pins and the config port.
  modport master (
    output track_in, data_output, cfg_shift, cfg_in, cfg_commit,
    input  track_out, track_oe, data_input, cfg_out, cfg_loaded, cfg_error, conflict
  );

  // Connection block side.
  modport slave (
    input  track_in, data_output, cfg_shift, cfg_in, cfg_commit,
    output track_out, track_oe, data_input, cfg_out, cfg_loaded, cfg_error, conflict
  );
endinterface

// File: rtl/data_connection_block_cfg.sv
// Scan-configured connection block: a shadow chain is shifted in serially and committed
// atomically into the active array, which routes tracks to input pins and output pins to tracks.
module data_connection_block_cfg #(
  parameter int unsigned W       = 16,
  parameter int unsigned WW      = 4,
  parameter int unsigned DATAIN  = 4,
  parameter int unsigned DATAOUT = 3,
  parameter int unsigned REG_IN  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  data_connection_block_cfg_if.slave bus
);

  localparam int unsigned NCFG  = W * (DATAIN + DATAOUT);
  localparam int unsigned CW    = $clog2(NCFG + 1);
  localparam int unsigned NIN   = WW * DATAIN;
  localparam int unsigned OBASE = W * DATAIN;

  logic [NCFG-1:0] shadow_q, shadow_d;
  logic [NCFG-1:0] active_q, active_d;
  logic [CW-1:0]   count_q, count_d;
  logic            cfg_error_q, cfg_error_d;
  logic            conflict_q, conflict_d;

  logic            loaded_c;
  logic            accept_c;
  logic [NIN-1:0]  din_c;
  logic            multi_sel_c;
  logic [W-1:0]    oe_c;
  logic [W-1:0]    tout_c;
  logic            multi_drv_c;

  // Config chain next state: shift, commit acceptance, shift counter and error pulse.
  always_comb begin
    loaded_c    = (count_q == CW'(NCFG));
    accept_c    = bus.cfg_commit & loaded_c;
    shadow_d    = shadow_q;
    active_d    = active_q;
    count_d     = count_q;
    cfg_error_d = bus.cfg_commit & ~loaded_c;
    conflict_d  = multi_sel_c | multi_drv_c;
    if (bus.cfg_shift) begin
      shadow_d = {bus.cfg_in, shadow_q[NCFG-1:1]};
    end
    // Active takes the pre-shift shadow even when a shift lands on the same edge.
    if (accept_c) begin
      active_d = shadow_q;
      count_d  = bus.cfg_shift ? CW'(1) : CW'(0);
    end else if (bus.cfg_shift && !loaded_c) begin
      count_d  = count_q + CW'(1);
    end
  end

  // Input selection: lowest-index selected track wins; extra selections flag a conflict.
  always_comb begin : p_in_sel
    logic [NIN-1:0] hit_v;
    hit_v       = '0;
    din_c       = '0;
    multi_sel_c = 1'b0;
    for (int i = 0; i < int'(DATAIN); i++) begin
      for (int j = 0; j < int'(W); j++) begin
        if (active_q[j + i*int'(W)]) begin
          if (hit_v[(j % int'(WW)) + i*int'(WW)]) begin
            multi_sel_c = 1'b1;
          end else begin
            hit_v[(j % int'(WW)) + i*int'(WW)] = 1'b1;
            din_c[(j % int'(WW)) + i*int'(WW)] = bus.track_in[j];
          end
        end
      end
    end
  end

  // Output drive: lowest-index enabled pin drives each track; a second driver flags a conflict.
  always_comb begin : p_out_drv
    logic [W-1:0] oe_v;
    logic [W-1:0] tout_v;
    oe_v        = '0;
    tout_v      = '0;
    multi_drv_c = 1'b0;
    for (int j = 0; j < int'(W); j++) begin
      for (int i = 0; i < int'(DATAOUT); i++) begin
        if (active_q[int'(OBASE) + j + i*int'(W)]) begin
          if (oe_v[j]) begin
            multi_drv_c = 1'b1;
          end else begin
            oe_v[j]   = 1'b1;
            tout_v[j] = bus.data_output[(j % int'(WW)) + i*int'(WW)];
          end
        end
      end
    end
    oe_c   = oe_v;
    tout_c = tout_v;
  end

  // Config and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      count_q     <= '0;
      cfg_error_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      count_q     <= count_d;
      cfg_error_q <= cfg_error_d;
      conflict_q  <= conflict_d;
    end
  end

  // Optional one-cycle input register on the logic-block side.
  if (REG_IN != 0) begin : g_reg_in
    logic [NIN-1:0] din_q;
    // Register the selected track values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) din_q <= '0;
      else        din_q <= din_c;
    end
    assign bus.data_input = din_q;
  end else begin : g_comb_in
    assign bus.data_input = din_c;
  end

  assign bus.track_oe   = oe_c;
  assign bus.track_out  = tout_c;
  assign bus.cfg_out    = shadow_q[0];
  assign bus.cfg_loaded = loaded_c;
  assign bus.cfg_error  = cfg_error_q;
  assign bus.conflict   = conflict_q;

endmodule

// File: tb/tb_data_connection_block_cfg.sv
// Randomised bench for data_connection_block_cfg: a combinational and a registered-input
// instance share stimulus and are compared against a rule-level model of the config array.
module tb_data_connection_block_cfg;

  localparam int unsigned W       = 16;
  localparam int unsigned WW      = 4;
  localparam int unsigned DATAIN  = 4;
  localparam int unsigned DATAOUT = 3;
  localparam int unsigned NCFG    = W * (DATAIN + DATAOUT);
  localparam int unsigned NIN     = WW * DATAIN;
  localparam int unsigned NOUT    = WW * DATAOUT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0]    tin   = '0;
  logic [NOUT-1:0] dout  = '0;
  logic            shift = 1'b0;
  logic            cin   = 1'b0;
  logic            commit = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  bit [NCFG-1:0] m_shadow, m_active;
  int            m_count;
  bit            m_err, m_conf;
  bit [NIN-1:0]  m_din_reg;

  always #5 clk = ~clk;

  data_connection_block_cfg_if #(.W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT)) b0 ();
  data_connection_block_cfg_if #(.W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT)) b1 ();

  assign b0.track_in = tin;   assign b1.track_in = tin;
  assign b0.data_output = dout; assign b1.data_output = dout;
  assign b0.cfg_shift = shift; assign b1.cfg_shift = shift;
  assign b0.cfg_in = cin;     assign b1.cfg_in = cin;
  assign b0.cfg_commit = commit; assign b1.cfg_commit = commit;

  data_connection_block_cfg #(.W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .REG_IN(0))
    u_dut_comb (.clk(clk), .rst_n(rst_n), .bus(b0));
  data_connection_block_cfg #(.W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .REG_IN(1))
    u_dut_reg (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pin bit k+p*WW reads the first track j (j%WW==k) whose select bit is set.
  function automatic bit [NIN-1:0] f_din(input bit [NCFG-1:0] act, input bit [W-1:0] t);
    bit [NIN-1:0] r = '0;
    for (int p = 0; p < int'(DATAIN); p++)
      for (int k = 0; k < int'(WW); k++)
        for (int j = k; j < int'(W); j += int'(WW))
          if (act[j + p*int'(W)]) begin
            r[k + p*int'(WW)] = t[j];
            break;
          end
    return r;
  endfunction

  function automatic bit [W-1:0] f_oe(input bit [NCFG-1:0] act);
    bit [W-1:0] r = '0;
    for (int j = 0; j < int'(W); j++)
      for (int p = 0; p < int'(DATAOUT); p++)
        r[j] = r[j] | act[int'(W*DATAIN) + j + p*int'(W)];
    return r;
  endfunction

  function automatic bit [W-1:0] f_tout(input bit [NCFG-1:0] act, input bit [NOUT-1:0] d);
    bit [W-1:0] r = '0;
    for (int j = 0; j < int'(W); j++)
      for (int p = 0; p < int'(DATAOUT); p++)
        if (act[int'(W*DATAIN) + j + p*int'(W)]) begin
          r[j] = d[(j % int'(WW)) + p*int'(WW)];
          break;
        end
    return r;
  endfunction

  function automatic bit f_conf(input bit [NCFG-1:0] act);
    int cnt;
    bit r = 1'b0;
    for (int p = 0; p < int'(DATAIN); p++)
      for (int k = 0; k < int'(WW); k++) begin
        cnt = 0;
        for (int j = k; j < int'(W); j += int'(WW)) cnt += int'(act[j + p*int'(W)]);
        if (cnt > 1) r = 1'b1;
      end
    for (int j = 0; j < int'(W); j++) begin
      cnt = 0;
      for (int p = 0; p < int'(DATAOUT); p++) cnt += int'(act[int'(W*DATAIN) + j + p*int'(W)]);
      if (cnt > 1) r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_count = 0; m_err = 0; m_conf = 0; m_din_reg = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic on_edge();
    bit acc;
    acc = commit && (m_count == int'(NCFG));
    m_din_reg = f_din(m_active, tin);
    m_conf    = f_conf(m_active);
    m_err     = commit && !acc;
    if (acc) m_active = m_shadow;
    if (acc) m_count = shift ? 1 : 0;
    else if (shift && m_count < int'(NCFG)) m_count++;
    if (shift) m_shadow = {cin, m_shadow[NCFG-1:1]};
  endtask

  task automatic check_all();
    chk("cfg_out",    b0.cfg_out,    m_shadow[0]);
    chk("cfg_loaded", b0.cfg_loaded, m_count == int'(NCFG));
    chk("cfg_error",  b0.cfg_error,  m_err);
    chk("conflict",   b0.conflict,   m_conf);
    chk("track_oe",   b0.track_oe,   f_oe(m_active));
    chk("track_out",  b0.track_out,  f_tout(m_active, dout));
    chk("din_comb",   b0.data_input, f_din(m_active, tin));
    chk("din_reg",    b1.data_input, m_din_reg);
    chk("conflict_r", b1.conflict,   m_conf);
  endtask

  task automatic step(input bit s, input bit c, input bit cm);
    shift = s; cin = c; commit = cm;
    @(posedge clk);
    on_edge();
    #1;
    shift = 1'b0; cin = 1'b0; commit = 1'b0;
    check_all();
  endtask

  task automatic shift_in(input bit [NCFG-1:0] pat);
    for (int k = 0; k < int'(NCFG); k++) step(1'b1, pat[k], 1'b0);
  endtask

  task automatic load(input bit [NCFG-1:0] pat);
    shift_in(pat);
    step(1'b0, 1'b0, 1'b1);
  endtask

  function automatic bit [NCFG-1:0] rand_pat();
    bit [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[NCFG-1:0];
  endfunction

  initial begin
    bit [NCFG-1:0] pat;
    bit [NIN-1:0]  e_din;
    bit [W-1:0]    e_w;
    bit            prev5;

    // Reset with every input driven
    model_reset();
    tin = W'($urandom); dout = NOUT'($urandom); shift = 1'b1; cin = 1'b1; commit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    tin = '0; dout = '0; shift = 1'b0; cin = 1'b0; commit = 1'b0;
    rst_n = 1'b1;

    // Commit one shift short of a full load is rejected
    for (int k = 0; k < int'(NCFG) - 1; k++) step(1'b1, 1'($urandom), 1'b0);
    chk("loaded_short", b0.cfg_loaded, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("err_pulse", b0.cfg_error, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("err_clear", b0.cfg_error, 1'b0);
    chk("active_empty_oe", b0.track_oe, '0);

    // Walking input bit
    for (int i = 0; i < int'(DATAIN); i++)
      for (int j = 0; j < int'(W); j++) begin
        pat = '0; pat[j + i*int'(W)] = 1'b1;
        load(pat);
        tin = 16'hA5C3;
        #1;
        e_din = '0; e_din[(j % int'(WW)) + i*int'(WW)] = tin[j];
        chk("walk_in", b0.data_input, e_din);
        chk("walk_in_oe", b0.track_oe, '0);
        check_all();
      end

    // Walking output bit
    for (int i = 0; i < int'(DATAOUT); i++)
      for (int j = 0; j < int'(W); j++) begin
        pat = '0; pat[int'(W*DATAIN) + j + i*int'(W)] = 1'b1;
        load(pat);
        dout = 12'h9E7;
        #1;
        e_w = '0; e_w[j] = 1'b1;
        chk("walk_out_oe", b0.track_oe, e_w);
        e_w = '0; e_w[j] = dout[(j % int'(WW)) + i*int'(WW)];
        chk("walk_out", b0.track_out, e_w);
        check_all();
      end

    // Two tracks selecting data_input[0]
    pat = '0; pat[0] = 1'b1; pat[4] = 1'b1;
    load(pat);
    tin = 16'h0010;
    #1;
    chk("sel_lowest", b0.data_input[0], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("conflict_sel", b0.conflict, 1'b1);

    // Two pins driving track 0
    pat = '0; pat[64] = 1'b1; pat[80] = 1'b1;
    load(pat);
    dout = 12'h010;
    #1;
    chk("drv_lowest", b0.track_out[0], 1'b0);
    chk("drv_oe", b0.track_oe[0], 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("conflict_drv", b0.conflict, 1'b1);

    // Registered input path: data_input[1] follows track_in[5] one cycle late
    pat = '0; pat[5] = 1'b1;
    load(pat);
    for (int n = 0; n < 20; n++) begin
      prev5 = tin[5];
      tin = ~tin ^ (W'($urandom) & ~W'(16'h0020));
      #1;
      chk("regin_hold", b1.data_input[1], prev5);
      chk("comb_now", b0.data_input[1], tin[5]);
      step(1'b0, 1'b0, 1'b0);
      chk("regin_delay", b1.data_input[1], tin[5]);
    end

    // Random configurations with random traffic
    for (int n = 0; n < 4; n++) begin
      load(rand_pat());
      for (int c = 0; c < 8; c++) begin
        tin = W'($urandom); dout = NOUT'($urandom);
        step(1'b0, 1'b0, 1'b0);
      end
    end

    // Random shift/commit mix
    for (int n = 0; n < 400; n++) begin
      tin = W'($urandom); dout = NOUT'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0));
    end

    // Shift and commit on the same edge
    pat = rand_pat();
    shift_in(pat);
    step(1'b1, 1'b1, 1'b1);
    chk("sc_oe", b0.track_oe, f_oe(pat));
    chk("sc_loaded", b0.cfg_loaded, 1'b0);
    for (int k = 0; k < int'(NCFG) - 2; k++) step(1'b1, 1'($urandom), 1'b0);
    chk("sc_loaded_early", b0.cfg_loaded, 1'b0);
    step(1'b1, 1'($urandom), 1'b0);
    chk("sc_loaded_full", b0.cfg_loaded, 1'b1);

    // Asynchronous reset in the middle of a load
    load(rand_pat());
    for (int k = 0; k < 7; k++) step(1'b1, 1'($urandom), 1'b0);
    tin = W'($urandom); dout = NOUT'($urandom);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_oe", b0.track_oe, '0);
    chk("rst_din_reg", b1.data_input, '0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("rst_commit_rejected", b0.cfg_error, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_connection_block_cfg.md
# data_connection_block_cfg

Parametrised, scan-configured connection block between a W-track routing channel and one logic block's data pins. Configuration is shifted serially into a shadow chain and committed atomically to an active array. The active array selects which track feeds each data-input bit and which data-output bit drives each track. It adds over-driver conflict detection and an optional input register, and sits between the switch-box channel and the logic-block pins.

## Interface
- W, 16: routing tracks in the channel; must be a multiple of WW.
- WW, 4: bits per data pin.
- DATAIN, 4: logic-block input pins.
- DATAOUT, 3: logic-block output pins.
- REG_IN, 0: 1 registers data_input; 0 makes it combinational.
- Derived NCFG = W*(DATAIN+DATAOUT), CW = clog2(NCFG+1).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- track_in  in  W  current track values.
- track_out  out  W  values this block drives onto the tracks.
- track_oe  out  W  per-track drive enable.
- data_input  out  WW*DATAIN  to logic-block input pins.
- data_output  in  WW*DATAOUT  from logic-block output pins.
- cfg_shift  in  1  shift one configuration bit.
- cfg_in  in  1  serial configuration data.
- cfg_out  out  1  shadow[0], for chaining the next block.
- cfg_commit  in  1  copy shadow to active.
- cfg_loaded  out  1  NCFG or more shifts since the last accepted commit or reset.
- cfg_error  out  1  one-cycle pulse when a commit is rejected.
- conflict  out  1  the active configuration has a multi-select or a multi-driver.

## Operation
- Bit layout is the same for shadow and active. Bit j+i*W, i<DATAIN, connects track j to data_input[(j%WW)+i*WW]. Bit j+i*W+DATAIN*W connects data_output[(j%WW)+i*WW] to track j.
- Shift: when cfg_shift=1, shadow <= {cfg_in, shadow[NCFG-1:1]}. The first bit shifted ends at bit 0 after NCFG shifts.
- Shift counter: increments on each shift and saturates at NCFG. cfg_loaded = (count==NCFG).
- Commit accepted (cfg_commit=1 and cfg_loaded=1):
  - active <= shadow.
  - count <= 0, or count <= 1 if cfg_shift is also high.
  - Shadow is not cleared.
- Commit rejected (cfg_commit=1 and cfg_loaded=0): active unchanged and cfg_error=1 for that next cycle.
- Simultaneous shift and accepted commit: active takes the pre-shift shadow, and the shift still occurs.
- Input selection: each data_input bit takes the lowest-index track whose bit is set. With no bit set it reads 0.
- Output drive:
  - track_oe[j] = OR of all output bits for track j.
  - track_out[j] comes from the lowest-index output pin that enables track j; it is 0 when track_oe[j]=0.
- conflict: registered. It is recomputed from active every cycle and is set when either holds:
  - any data_input bit has more than one track selected;
  - any track has more than one driver.
- No loopback: a track this block drives still feeds data_input through track_in. External tristate resolution is outside this block.

## Timing
- Reset values: shadow=0, active=0, count=0, track_oe=0, track_out=0, data_input=0, cfg_out=0, cfg_loaded=0, cfg_error=0, conflict=0.
- Reset mid-shift or mid-commit aborts everything. The configuration returns to empty, so nothing is driven.
- Commit at edge k: track_oe and track_out reflect the new active combinationally after edge k. data_input reflects it after edge k when REG_IN=0, and after edge k+1 when REG_IN=1. conflict is valid after edge k+1.
- Data path:
  - REG_IN=0: data_input is combinational from track_in.
  - REG_IN=1: data_input is one cycle behind track_in.
  - track_out is always combinational from data_output.
- cfg_out changes only on shifting edges, so chained blocks see a one-cycle-per-block serial path.

## Test plan
- Reset with all inputs driven: every output is 0 and track_oe=0. Deassert reset and shift 111 times, then commit: cfg_error pulses for one cycle and active stays 0.
- Walking input bit, W=16, WW=4, DATAIN=4, DATAOUT=3, REG_IN=0: load a single 1 at bit j+16i, commit, drive track_in=0xA5C3. Require data_input[(j%4)+4i]=track_in[j], all other bits 0, and track_oe=0, for all 64 positions.
- Walking output bit: load a single 1 at bit 64+j+16i, commit, drive data_output=0x9E7. Require track_oe=1<<j and track_out[j]=data_output[(j%4)+4i], for all 48 positions.
- Conflicts:
  - Bits 0 and 4 set (tracks 0 and 4 both select data_input[0]): with track_in=0x0010, require data_input[0]=0 (track 0 wins) and conflict=1 one cycle after commit.
  - Bits 64 and 80 set (pins 0 and 1 both drive track 0): require pin 0's value on track_out[0] and conflict=1.
- REG_IN=1: toggle track_in each cycle with bit 5 committed. data_input[1] equals track_in[5] delayed exactly one cycle.
- Shift and commit in the same cycle after 112 shifts: active equals the pre-shift pattern, count=1, and cfg_loaded stays 0 until 111 more shifts. Assert rst_n low mid-sequence: outputs clear immediately.
